pipelined_subtractor: RTL
=========================

# pipelined_subtractor

Parametrised, pipelined N-bit subtractor computing Difference = In_A − In_B − Borrow_in. The borrow chain is split into STAGES equal slices, with one registered slice per stage. It is the multi-bit, clocked successor of the single-bit full subtractor and serves as the arithmetic core for datapath blocks that need full-rate subtraction at widths too wide for one combinational borrow ripple. It uses a valid/ready handshake on both sides and a global stall, and reports borrow and signed overflow.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES, and WIDTH ≥ 2.
- STAGES, 4, number of pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES.
- Clk  input  1  single clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- In_Valid  input  1  input operands valid.
- In_Ready  output  1  pipeline can accept an operand set this cycle.
- In_A  input  WIDTH  minuend.
- In_B  input  WIDTH  subtrahend.
- Borrow_in  input  1  borrow into bit 0.
- Out_Valid  output  1  result valid.
- Out_Ready  input  1  downstream accepts the result.
- Difference  output  WIDTH  (In_A − In_B − Borrow_in) mod 2^WIDTH.
- Borrow_out  output  1  borrow out of the MSB; 1 iff unsigned In_A < In_B + Borrow_in.
- Overflow  output  1  two's-complement overflow of the same operation.

## Operation
- Stage k (0..STAGES−1) subtracts slice k (bits k·SW .. k·SW+SW−1, LSB slice first) using the borrow registered by stage k−1. Stage 0 uses Borrow_in.
- Each stage registers:
  - its difference slice and slice borrow;
  - the not-yet-processed upper operand slices (input skew);
  - the already-computed lower difference slices (output deskew);
  - the operation's valid bit.
- Overflow is computed in the last stage as A[MSB] ≠ B[MSB] AND D[MSB] ≠ A[MSB]. The sign bits of A and B travel with the data.
- Global advance enable: adv = !Out_Valid || Out_Ready. When adv=1, every stage register loads from its predecessor. When adv=0, all stages hold.
- In_Ready = adv, a combinational function of Out_Valid and Out_Ready only. It never depends on In_Valid.
- Stage 0's valid bit loads In_Valid && In_Ready. Bubbles propagate as valid=0. Data registers of bubble stages may hold anything; outputs are only meaningful when Out_Valid=1.
- Difference, Borrow_out and Overflow are driven directly from last-stage registers. No combinational path runs from In_* to Out_*.
- Reset, asynchronous and at any time: all valid bits 0, Difference 0, Borrow_out 0, Overflow 0, In_Ready 1 (follows from Out_Valid=0). Operations in flight are discarded and not replayed.
- A borrow generated in slice 0 must propagate correctly through every slice, e.g. 0 − 0 − 1.

## Timing
- Transfer in: edge where In_Valid && In_Ready. Transfer out: edge where Out_Valid && Out_Ready.
- Latency: with no stall, the result is on Out_* and Out_Valid=1 after STAGES rising edges counted from and including the accepting edge. STAGES=1 gives one registered stage.
- Throughput: one operation per cycle while Out_Ready=1; back-to-back results appear on consecutive cycles.
- Stall: while Out_Valid=1 and Out_Ready=0, Out_* are stable, In_Ready=0, and no input is accepted. Releasing Out_Ready resumes the pipeline on the next edge with no loss or duplication.
- Output and acceptance in the same cycle (Out_Ready=1, In_Valid=1) are both honoured on the same edge.
- Order of results equals order of acceptance.

## Test plan
- WIDTH=16, STAGES=4, Out_Ready=1: 0x1234 − 0x0234, Bin=0 → 0x1000, Borrow_out=0, Overflow=0, exactly 4 edges after accept.
- 0x0000 − 0x0000, Bin=1 → 0xFFFF, Borrow_out=1, Overflow=0 (full borrow ripple across all 4 slices). 0x0000 − 0x0001, Bin=0 → 0xFFFF, Borrow_out=1.
- 0x8000 − 0x0001 → 0x7FFF, Overflow=1, Borrow_out=0. 0x7FFF − 0xFFFF → 0x8000, Overflow=1, Borrow_out=1.
- Stream 8 random vectors back-to-back, toggling Out_Ready pseudo-randomly → 8 correct results in order, stable while stalled, In_Ready==!Out_Valid||Out_Ready every cycle.
- Assert Reset asynchronously (mid-cycle) with 3 operations in flight → Out_Valid=0, Difference=0, Borrow_out=0, Overflow=0 immediately. After release, a new vector yields a correct result with no stale output.
- Repeat vectors 1–3 with STAGES=1 and STAGES=16 (WIDTH=16) → identical results; latency 1 and 16 respectively.

Source files
------------

// File: rtl/pipelined_subtractor_if.sv
// Operand/result handshake bundle for pipelined_subtractor.
// The master side supplies operands and Out_Ready; the slave side is the subtractor.
interface pipelined_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             In_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] In_A;
    logic [WIDTH-1:0] In_B;
    logic             Borrow_in;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [WIDTH-1:0] Difference;
    logic             Borrow_out;
    logic             Overflow;

    modport master (
        output In_Valid, In_A, In_B, Borrow_in, Out_Ready,
        input  In_Ready, Out_Valid, Difference, Borrow_out, Overflow
    );

    modport slave (
        input  In_Valid, In_A, In_B, Borrow_in, Out_Ready,
        output In_Ready, Out_Valid, Difference, Borrow_out, Overflow
    );
endinterface

// File: rtl/pipelined_subtractor.sv
// Pipelined WIDTH-bit subtractor, Difference = A - B - Borrow_in, one SW-bit borrow slice per stage.
// Whole pipeline advances together on !Out_Valid || Out_Ready; outputs come straight from last-stage flops.
module pipelined_subtractor #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input logic                   Clk,
    input logic                   Reset,
    pipelined_subtractor_if.slave io
);
    localparam int unsigned SW = WIDTH / STAGES;

    logic             adv;
    logic             valid_chain [STAGES+1];
    logic             brw_chain   [STAGES+1];
    logic [WIDTH-1:0] diff_chain  [STAGES+1];
    // Unprocessed operand bits, shifted so the next slice always sits at bit 0.
    logic [WIDTH-1:0] a_chain     [STAGES];
    logic [WIDTH-1:0] b_chain     [STAGES];
    logic             ovf_d;
    logic             ovf_q;

    assign adv         = !valid_chain[STAGES] || io.Out_Ready;
    assign io.In_Ready = adv;

    assign valid_chain[0] = io.In_Valid && adv;
    assign brw_chain[0]   = io.Borrow_in;
    assign diff_chain[0]  = '0;
    assign a_chain[0]     = io.In_A;
    assign b_chain[0]     = io.In_B;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    slice_c;
        logic             brw_c;
        logic             valid_d;
        logic             valid_q;
        logic             brw_d;
        logic             brw_q;
        logic [WIDTH-1:0] diff_d;
        logic [WIDTH-1:0] diff_q;

        assign {brw_c, slice_c} = {1'b0, a_chain[k][SW-1:0]}
                                - {1'b0, b_chain[k][SW-1:0]}
                                - (SW+1)'(brw_chain[k]);

        // New slice enters at the top; earlier slices shift down toward bit 0.
        always_comb begin
            valid_d = valid_q;
            brw_d   = brw_q;
            diff_d  = diff_q;
            if (adv) begin
                valid_d = valid_chain[k];
                brw_d   = brw_c;
                diff_d  = (diff_chain[k] >> SW) | (WIDTH'(slice_c) << (WIDTH - SW));
            end
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                valid_q <= 1'b0;
                brw_q   <= 1'b0;
                diff_q  <= '0;
            end else begin
                valid_q <= valid_d;
                brw_q   <= brw_d;
                diff_q  <= diff_d;
            end
        end

        assign valid_chain[k+1] = valid_q;
        assign brw_chain[k+1]   = brw_q;
        assign diff_chain[k+1]  = diff_q;

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_d;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_d;
            logic [WIDTH-1:0] b_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (adv) begin
                    a_d = a_chain[k] >> SW;
                    b_d = b_chain[k] >> SW;
                end
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign a_chain[k+1] = a_q;
            assign b_chain[k+1] = b_q;
        end else begin : g_sign
            // Top slice carries the operand sign bits at position SW-1.
            always_comb begin
                ovf_d = ovf_q;
                if (adv) begin
                    ovf_d = (a_chain[k][SW-1] != b_chain[k][SW-1])
                         && (slice_c[SW-1] != a_chain[k][SW-1]);
                end
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign io.Out_Valid  = valid_chain[STAGES];
    assign io.Difference = diff_chain[STAGES];
    assign io.Borrow_out = brw_chain[STAGES];
    assign io.Overflow   = ovf_q;
endmodule
